// File: rtl/sd_clk_gen.sv
// SPI/SD clock generator: emits bursts of N clock periods at a slow or fast rate,
// with registered leading/trailing edge strobes for clk-domain shifters.
module sd_clk_gen #(
   parameter int unsigned CNT_W     = 9,
   parameter int unsigned SLOW_HALF = 124,
   parameter int unsigned FAST_HALF = 1,
   parameter bit          CPOL      = 1'b0,
   parameter int unsigned NCYC_W    = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fast_sel,
   input  logic              start,
   input  logic [NCYC_W-1:0] n_cycles,
   input  logic              abort,
   output logic              spi_clk,
   output logic              lead_stb,
   output logic              trail_stb,
   output logic              busy,
   output logic              done
);

   typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

   state_t            r_state, w_state_nx;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nx;
   logic [CNT_W-1:0]  r_half, w_half_nx;
   logic [NCYC_W-1:0] r_rem, w_rem_nx;
   logic              r_abort, w_abort_nx;
   logic              r_spi_clk, w_spi_clk_nx;
   logic              r_lead, w_lead_nx;
   logic              r_trail, w_trail_nx;
   logic              r_busy, w_busy_nx;
   logic              r_done, w_done_nx;

   // State and output registers; reset wins over everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_half    <= '0;
         r_rem     <= '0;
         r_abort   <= 1'b0;
         r_spi_clk <= CPOL;
         r_lead    <= 1'b0;
         r_trail   <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_nx;
         r_cnt     <= w_cnt_nx;
         r_half    <= w_half_nx;
         r_rem     <= w_rem_nx;
         r_abort   <= w_abort_nx;
         r_spi_clk <= w_spi_clk_nx;
         r_lead    <= w_lead_nx;
         r_trail   <= w_trail_nx;
         r_busy    <= w_busy_nx;
         r_done    <= w_done_nx;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      w_state_nx   = r_state;
      w_cnt_nx     = r_cnt;
      w_half_nx    = r_half;
      w_rem_nx     = r_rem;
      w_abort_nx   = r_abort;
      w_spi_clk_nx = r_spi_clk;
      w_lead_nx    = 1'b0;
      w_trail_nx   = 1'b0;
      w_busy_nx    = r_busy;
      w_done_nx    = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_cnt_nx     = '0;
            w_spi_clk_nx = CPOL;
            w_abort_nx   = 1'b0;
            w_busy_nx    = 1'b0;
            if (start) begin
               w_half_nx = fast_sel ? CNT_W'(FAST_HALF) : CNT_W'(SLOW_HALF);
               w_rem_nx  = n_cycles;
               if (n_cycles != '0) begin
                  w_state_nx = S_RUN;
                  w_busy_nx  = 1'b1;
               end else begin
                  w_done_nx = 1'b1;
               end
            end
         end
         S_RUN: begin
            w_abort_nx = r_abort | abort;
            if (r_cnt == r_half) begin
               w_cnt_nx     = '0;
               w_spi_clk_nx = ~r_spi_clk;
               if (r_spi_clk == CPOL) begin
                  w_lead_nx = 1'b1;
               end else begin
                  // Trailing edge: count down and end the burst on the last one or an abort.
                  w_trail_nx = 1'b1;
                  w_rem_nx   = r_rem - NCYC_W'(1);
                  if ((r_rem == NCYC_W'(1)) || r_abort || abort) begin
                     w_state_nx = S_IDLE;
                     w_busy_nx  = 1'b0;
                     w_done_nx  = 1'b1;
                     w_abort_nx = 1'b0;
                  end
               end
            end else begin
               w_cnt_nx = r_cnt + CNT_W'(1);
            end
         end
      endcase
   end

   assign spi_clk   = r_spi_clk;
   assign lead_stb  = r_lead;
   assign trail_stb = r_trail;
   assign busy      = r_busy;
   assign done      = r_done;

endmodule

// File: tb/tb_sd_clk_gen.sv
// Directed bench for sd_clk_gen: CPOL=0 instance for most scenarios, CPOL=1 instance
// for idle-polarity and back-to-back checks.
module tb_sd_clk_gen;

   logic        clk = 1'b0;
   logic        reset;
   logic        fast0, start0, abort0;
   logic [15:0] n0;
   logic        spi0, lead0, trail0, busy0, done0;
   logic        fast1, start1, abort1;
   logic [15:0] n1;
   logic        spi1, lead1, trail1, busy1, done1;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   sd_clk_gen #(.CPOL(1'b0)) dut0 (
      .clk(clk), .reset(reset), .fast_sel(fast0), .start(start0), .n_cycles(n0),
      .abort(abort0), .spi_clk(spi0), .lead_stb(lead0), .trail_stb(trail0),
      .busy(busy0), .done(done0));

   sd_clk_gen #(.CPOL(1'b1)) dut1 (
      .clk(clk), .reset(reset), .fast_sel(fast1), .start(start1), .n_cycles(n1),
      .abort(abort1), .spi_clk(spi1), .lead_stb(lead1), .trail_stb(trail1),
      .busy(busy1), .done(done1));

   // Follows a dut0 burst from the cycle after its start until busy falls, collecting statistics.
   task automatic run0(input int bound, input bit toggle_fs, input int abort_at, input bit hold_start,
                       output int busy_cyc, output int nlead, output int ntrail, output int ndone,
                       output int both, output int min_gap, output int max_gap,
                       output int first_lead, output int timeout);
      int n, last_edge;
      busy_cyc = 0; nlead = 0; ntrail = 0; ndone = 0; both = 0;
      min_gap = 1 << 30; max_gap = 0; first_lead = -1; timeout = 0;
      n = 0; last_edge = -1;
      @(negedge clk);
      if (!hold_start) start0 = 1'b0;
      forever begin
         if (lead0 && trail0) both++;
         if (done0) ndone++;
         if (lead0 || trail0) begin
            if (last_edge >= 0) begin
               if (n - last_edge < min_gap) min_gap = n - last_edge;
               if (n - last_edge > max_gap) max_gap = n - last_edge;
            end
            last_edge = n;
         end
         if (lead0) begin
            nlead++;
            if (first_lead < 0) first_lead = n;
            if (nlead == abort_at) abort0 = 1'b1;
         end else begin
            abort0 = 1'b0;
         end
         if (trail0) ntrail++;
         if (busy0 !== 1'b1) break;
         busy_cyc++;
         if (busy_cyc > bound) begin timeout = 1; break; end
         if (toggle_fs) fast0 = ~fast0;
         @(negedge clk);
         n++;
      end
      start0 = 1'b0;
      abort0 = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      tests++; if (spi0 !== 1'b0) begin fails++; $display("FAIL reset_spi0: got %b expected 0", spi0); end
      tests++; if (spi1 !== 1'b1) begin fails++; $display("FAIL reset_spi1: got %b expected 1", spi1); end
      tests++; if ({busy0, done0, lead0, trail0} !== 4'b0000) begin
         fails++; $display("FAIL reset_outs0: got %b expected 0000", {busy0, done0, lead0, trail0}); end
      tests++; if ({busy1, done1, lead1, trail1} !== 4'b0000) begin
         fails++; $display("FAIL reset_outs1: got %b expected 0000", {busy1, done1, lead1, trail1}); end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_fast_burst();
      int bc, nl, nt, nd, bo, mn, mx, fl, to;
      fast0 = 1'b1; n0 = 16'd8; start0 = 1'b1;
      run0(100, 1'b0, 0, 1'b0, bc, nl, nt, nd, bo, mn, mx, fl, to);
      tests++; if (to != 0) begin fails++; $display("FAIL fast_timeout: got %0d expected 0", to); end
      tests++; if (bc != 32) begin fails++; $display("FAIL fast_busy_cycles: got %0d expected 32", bc); end
      tests++; if (nl != 8 || nt != 8) begin fails++; $display("FAIL fast_edges: got lead=%0d trail=%0d expected 8/8", nl, nt); end
      tests++; if (mn != 2 || mx != 2) begin fails++; $display("FAIL fast_gap: got min=%0d max=%0d expected 2/2", mn, mx); end
      tests++; if (fl != 2) begin fails++; $display("FAIL fast_first_lead: got %0d expected 2", fl); end
      tests++; if (nd != 1 || done0 !== 1'b1) begin fails++; $display("FAIL fast_done: got count=%0d done=%b expected 1/1", nd, done0); end
      tests++; if (bo != 0) begin fails++; $display("FAIL fast_both_strobes: got %0d expected 0", bo); end
      @(negedge clk);
      tests++; if ({spi0, done0, busy0} !== 3'b000) begin
         fails++; $display("FAIL fast_after: got spi/done/busy=%b expected 000", {spi0, done0, busy0}); end
   endtask

   task automatic test_slow_burst();
      int bc, nl, nt, nd, bo, mn, mx, fl, to;
      fast0 = 1'b0; n0 = 16'd80; start0 = 1'b1;
      run0(25000, 1'b1, 0, 1'b0, bc, nl, nt, nd, bo, mn, mx, fl, to);
      tests++; if (to != 0) begin fails++; $display("FAIL slow_timeout: got %0d expected 0", to); end
      tests++; if (bc != 20000) begin fails++; $display("FAIL slow_busy_cycles: got %0d expected 20000", bc); end
      tests++; if (nl != 80 || nt != 80) begin fails++; $display("FAIL slow_edges: got lead=%0d trail=%0d expected 80/80", nl, nt); end
      tests++; if (mn != 125 || mx != 125) begin fails++; $display("FAIL slow_phase: got min=%0d max=%0d expected 125/125", mn, mx); end
      tests++; if (fl != 125) begin fails++; $display("FAIL slow_first_lead: got %0d expected 125", fl); end
      tests++; if (nd != 1) begin fails++; $display("FAIL slow_done: got %0d expected 1", nd); end
      fast0 = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_zero_cycles();
      fast0 = 1'b1; n0 = 16'd0; start0 = 1'b1; abort0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0; abort0 = 1'b0;
      tests++; if ({done0, busy0, lead0, trail0, spi0} !== 5'b10000) begin
         fails++; $display("FAIL zero_done_cycle: got done/busy/lead/trail/spi=%b expected 10000",
                           {done0, busy0, lead0, trail0, spi0}); end
      @(negedge clk);
      tests++; if ({done0, busy0} !== 2'b00) begin
         fails++; $display("FAIL zero_after: got done/busy=%b expected 00", {done0, busy0}); end
   endtask

   task automatic test_abort();
      int bc, nl, nt, nd, bo, mn, mx, fl, to;
      fast0 = 1'b1; n0 = 16'd10; start0 = 1'b1;
      run0(100, 1'b0, 3, 1'b1, bc, nl, nt, nd, bo, mn, mx, fl, to);
      tests++; if (bc != 12) begin fails++; $display("FAIL abort_busy_cycles: got %0d expected 12", bc); end
      tests++; if (nl != 3 || nt != 3) begin fails++; $display("FAIL abort_edges: got lead=%0d trail=%0d expected 3/3", nl, nt); end
      tests++; if (nd != 1 || to != 0) begin fails++; $display("FAIL abort_done: got count=%0d timeout=%0d expected 1/0", nd, to); end
      @(negedge clk);
      tests++; if ({spi0, busy0, done0} !== 3'b000) begin
         fails++; $display("FAIL abort_after: got spi/busy/done=%b expected 000", {spi0, busy0, done0}); end
   endtask

   task automatic test_reset_mid_burst();
      int bc, nl, nt, nd, bo, mn, mx, fl, to, waited, dcount;
      fast0 = 1'b0; n0 = 16'd3; start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      waited = 0;
      while (spi0 !== 1'b1 && waited < 400) begin @(negedge clk); waited++; end
      tests++; if (spi0 !== 1'b1) begin fails++; $display("FAIL rst_mid_reach_high: got %b expected 1", spi0); end
      repeat (10) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      tests++; if ({spi0, busy0, done0, lead0, trail0} !== 5'b00000) begin
         fails++; $display("FAIL rst_mid_outs: got spi/busy/done/lead/trail=%b expected 00000",
                           {spi0, busy0, done0, lead0, trail0}); end
      dcount = 0;
      repeat (5) begin @(negedge clk); if (done0 || busy0) dcount++; end
      tests++; if (dcount != 0) begin fails++; $display("FAIL rst_mid_no_done: got %0d expected 0", dcount); end
      fast0 = 1'b1; n0 = 16'd2; start0 = 1'b1;
      run0(100, 1'b0, 0, 1'b0, bc, nl, nt, nd, bo, mn, mx, fl, to);
      tests++; if (bc != 8 || nl != 2 || nt != 2 || nd != 1) begin
         fails++; $display("FAIL rst_mid_fresh: got busy=%0d lead=%0d trail=%0d done=%0d expected 8/2/2/1", bc, nl, nt, nd); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int nl, nt, nd, bc, bad_lead, last_edge, mn, mx, c;
      nl = 0; nt = 0; nd = 0; bc = 0; bad_lead = 0; last_edge = -1; mn = 1 << 30; mx = 0; c = 0;
      tests++; if (spi1 !== 1'b1) begin fails++; $display("FAIL b2b_idle_level: got %b expected 1", spi1); end
      fast1 = 1'b1; n1 = 16'd2; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      while (nd < 2 && c < 60) begin
         if (lead1) begin nl++; if (spi1 !== 1'b0) bad_lead++; end
         if (trail1) nt++;
         if (busy1) bc++;
         if (lead1 || trail1) begin
            if (last_edge >= 0) begin
               if (c - last_edge < mn) mn = c - last_edge;
               if (c - last_edge > mx) mx = c - last_edge;
            end
            last_edge = c;
         end
         if (done1) begin nd++; start1 = (nd == 1); end else start1 = 1'b0;
         if (nd < 2) begin @(negedge clk); c++; end
      end
      start1 = 1'b0;
      tests++; if (nd != 2) begin fails++; $display("FAIL b2b_done_count: got %0d expected 2", nd); end
      tests++; if (nl != 4 || nt != 4) begin fails++; $display("FAIL b2b_edges: got lead=%0d trail=%0d expected 4/4", nl, nt); end
      tests++; if (bad_lead != 0) begin fails++; $display("FAIL b2b_lead_dir: got %0d bad expected 0", bad_lead); end
      tests++; if (bc != 16) begin fails++; $display("FAIL b2b_busy_cycles: got %0d expected 16", bc); end
      tests++; if (mn != 2 || mx != 3) begin fails++; $display("FAIL b2b_phase: got min=%0d max=%0d expected 2/3", mn, mx); end
      @(negedge clk);
      tests++; if ({spi1, busy1, done1} !== 3'b100) begin
         fails++; $display("FAIL b2b_after: got spi/busy/done=%b expected 100", {spi1, busy1, done1}); end
   endtask

   initial begin
      reset = 1'b1;
      fast0 = 1'b0; start0 = 1'b0; abort0 = 1'b0; n0 = '0;
      fast1 = 1'b0; start1 = 1'b0; abort1 = 1'b0; n1 = '0;
      @(negedge clk);
      test_reset();
      test_fast_burst();
      test_slow_burst();
      test_zero_cycles();
      test_abort();
      test_reset_mid_burst();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
